// File: rtl/shift_pkg.sv
// Shared encodings and defaults for the multicycle shift unit.
// Build with SHIFT_MULTISTEP_EN to allow 4-bit steps while the count is large.
package shift_pkg;
  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;
endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: applies op to value by a small amount.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       amt,
  output logic [WIDTH-1:0] shifted
);
  always_comb begin
    shifted = value;
    case (op)
      OP_SLL:  shifted = value << amt;
      OP_SRL:  shifted = value >> amt;
      OP_SRA:  shifted = WIDTH'($signed(value) >>> amt);
      default: shifted = value;
    endcase
  end
endmodule

// File: rtl/seq_shift_unit.sv
// Iterative SLL/SRL/SRA unit with start/done handshake and held result.
// SHIFT_MULTISTEP_EN: shift by 4 per cycle while the remaining count is >= 4.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);
  state_e             state_q, state_d;
  op_e                op_q;
  logic [SHAMT_W-1:0] cnt_q, cnt_nxt;
  logic [WIDTH-1:0]   result_q, shifted;
  logic [2:0]         step;

`ifdef SHIFT_MULTISTEP_EN
  assign step = (cnt_q >= SHAMT_W'(4)) ? 3'd4 : 3'd1;
`else
  assign step = 3'd1;
`endif

  assign cnt_nxt = cnt_q - SHAMT_W'(step);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .value   (result_q),
    .amt     (step),
    .shifted (shifted)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (start)
          state_d = (shamt == '0 || op_e'(op) == OP_PASS) ? ST_DONE : ST_SHIFT;
      ST_SHIFT:
        if (cnt_nxt == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SLL;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE:
          if (start) begin
            result_q <= data_in;
            cnt_q    <= shamt;
            op_q     <= op_e'(op);
          end
        ST_SHIFT: begin
          result_q <= shifted;
          cnt_q    <= cnt_nxt;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: random and directed shifts vs. arithmetic model.
module tb_seq_shift_unit;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy, done;
  logic [31:0] result;

  seq_shift_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
    .shamt(shamt), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        q[$];
  int          compared = 0, mismatched = 0;
  logic [31:0] last_exp = '0;

  function automatic logic [31:0] model(logic [1:0] o, logic [31:0] d, int s);
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return 32'($signed(d) >>> s);
      default: return d;
    endcase
  endfunction

  function automatic int model_lat(logic [1:0] o, int s);
    if (o == 2'b11 || s == 0) return 1;
`ifdef SHIFT_MULTISTEP_EN
    return s / 4 + s % 4 + 1;
`else
    return s + 1;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.res);
        chk("latency", 32'(cyc - e.t0 + 1), 32'(e.lat));
        chk("busy_in_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic issue(logic [1:0] o, logic [31:0] d, logic [4:0] s);
    exp_t e;
    @(negedge clk);
    op = o; data_in = d; shamt = s; start = 1'b1;
    e.res = model(o, d, int'(s));
    e.lat = model_lat(o, int'(s));
    e.t0  = cyc + 1;
    q.push_back(e);
    last_exp = e.res;
    @(negedge clk);
    start = 1'b0;
    data_in = $urandom; shamt = 5'($urandom); op = 2'($urandom);
  endtask

  task automatic wait_idle(bit poke);
    int n = 0;
    while (busy && n < 200) begin
      if (poke && ($urandom_range(0, 3) == 0)) begin
        start = 1'b1; data_in = $urandom; shamt = 5'($urandom); op = 2'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    chk("held_result", result, last_exp);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; data_in = '0; shamt = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", {30'd0, busy, done}, 32'd0);

    issue(2'b00, 32'h0000_0001, 5'd4);  wait_idle(0);
    issue(2'b10, 32'h8000_0000, 5'd31); wait_idle(0);
    issue(2'b01, 32'hF000_0000, 5'd0);  wait_idle(0);
    issue(2'b11, 32'h1234_5678, 5'd7);  wait_idle(0);

    // Second start while busy must be ignored.
    issue(2'b00, 32'h0000_0001, 5'd8);
    @(negedge clk);
    start = 1'b1; data_in = 32'h0000_FFFF;
    @(negedge clk);
    start = 1'b0;
    wait_idle(0);

    // Start raised during the done cycle must not launch a new operation.
    issue(2'b01, 32'hA5A5_0000, 5'd2);
    for (int i = 0; i < 50 && !done; i++) @(negedge clk);
    start = 1'b1; data_in = 32'hDEAD_BEEF; shamt = 5'd3; op = 2'b00;
    @(negedge clk);
    start = 1'b0;
    wait_idle(0);
    repeat (10) @(negedge clk);

    // Reset mid-shift abandons the operation.
    issue(2'b01, 32'hFFFF_FFFF, 5'd20);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    chk("midrst_result", result, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    last_exp = 32'd0;
    repeat (30) @(negedge clk);
    chk("midrst_held", result, 32'd0);
    issue(2'b10, 32'h8765_4321, 5'd9); wait_idle(0);

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom), $urandom, 5'($urandom));
      wait_idle(1);
    end

    repeat (5) @(negedge clk);
    if (q.size() != 0) chk("missing_done", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
